// File: rtl/adc_readout_accum.sv
// Readout accumulator for the crossbar ADCs: decodes thermometer pairs and shift-accumulates the
// bit planes, then streams per-ADC results. Optional macro ADC_BUBBLE_CHECK_EN enables bubble detection.
module adc_readout_accum #(
    parameter int unsigned NUM_ADC     = 32,
    parameter int unsigned ADC_WIDTH   = 4,
    parameter int unsigned THERM_WIDTH = 15,
    parameter int unsigned NUM_PLANES  = 4,
    parameter int unsigned SETTLE_CYC  = 4,
    parameter int unsigned ACC_WIDTH   = 9,
    localparam int unsigned PlaneW = (NUM_PLANES > 1) ? $clog2(NUM_PLANES) : 1,
    localparam int unsigned IdxW   = (NUM_ADC > 1) ? $clog2(NUM_ADC) : 1,
    localparam int unsigned BusW   = THERM_WIDTH * NUM_ADC
) (
    input  logic                 CLK,
    input  logic                 RSTb,
    input  logic                 conv_done,
    input  logic [BusW-1:0]      outp,
    input  logic [BusW-1:0]      outn,
    output logic                 busy,
    output logic [PlaneW-1:0]    plane_idx,
    output logic                 res_valid,
    input  logic                 res_ready,
    output logic [ACC_WIDTH-1:0] res_data,
    output logic [IdxW-1:0]      res_idx,
    output logic                 res_last,
    output logic                 conv_err,
    output logic                 bubble_err
);

    localparam int unsigned CntW = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC) : 1;

    typedef enum logic [2:0] {
        StIdle,
        StSettle,
        StCapture,
        StAccum,
        StWait,
        StDrain
    } state_e;

    state_e                 state_q, state_d;
    logic [CntW-1:0]        cnt_q, cnt_d;
    logic [IdxW-1:0]        adc_idx_q, adc_idx_d;
    logic [PlaneW-1:0]      plane_q, plane_d;
    logic                   res_valid_q, res_valid_d;
    logic [ACC_WIDTH-1:0]   res_data_q, res_data_d;
    logic [IdxW-1:0]        res_idx_q, res_idx_d;
    logic                   res_last_q, res_last_d;
    logic                   conv_err_q, conv_err_d;
    logic [BusW-1:0]        cap_p_q, cap_n_q;
    logic [ACC_WIDTH-1:0]   acc_q [NUM_ADC];

    logic                   cap_en;
    logic                   acc_we;
    logic [THERM_WIDTH-1:0] cur_p, cur_n;
    logic [ADC_WIDTH-1:0]   pop_p, pop_n;
    logic signed [ADC_WIDTH:0] diff;
    logic [ACC_WIDTH-1:0]   contrib;
    logic [ACC_WIDTH-1:0]   acc_sum;
    logic [IdxW-1:0]        res_idx_nxt;

    // Decode the ADC currently being accumulated from the capture flops.
    always_comb begin
        cur_p = cap_p_q[int'(adc_idx_q) * THERM_WIDTH +: THERM_WIDTH];
        cur_n = cap_n_q[int'(adc_idx_q) * THERM_WIDTH +: THERM_WIDTH];
        pop_p = '0;
        pop_n = '0;
        for (int j = 0; j < THERM_WIDTH; j++) begin
            pop_p = pop_p + ADC_WIDTH'(cur_p[j]);
            pop_n = pop_n + ADC_WIDTH'(cur_n[j]);
        end
        diff    = $signed({1'b0, pop_p}) - $signed({1'b0, pop_n});
        contrib = {{(ACC_WIDTH - ADC_WIDTH - 1){diff[ADC_WIDTH]}}, diff} << plane_q;
        acc_sum = (plane_q == '0) ? contrib : acc_q[adc_idx_q] + contrib;
    end

    assign res_idx_nxt = res_idx_q + IdxW'(1);

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        adc_idx_d   = adc_idx_q;
        plane_d     = plane_q;
        res_valid_d = res_valid_q;
        res_data_d  = res_data_q;
        res_idx_d   = res_idx_q;
        res_last_d  = res_last_q;
        conv_err_d  = conv_err_q;
        cap_en      = 1'b0;
        acc_we      = 1'b0;

        if (conv_done && !(state_q == StIdle || state_q == StWait)) begin
            conv_err_d = 1'b1;
        end

        unique case (state_q)
            StIdle, StWait: begin
                if (conv_done) begin
                    state_d = StSettle;
                    cnt_d   = CntW'(SETTLE_CYC - 1);
                end
            end
            StSettle: begin
                if (cnt_q == '0) begin
                    state_d = StCapture;
                end else begin
                    cnt_d = cnt_q - CntW'(1);
                end
            end
            StCapture: begin
                cap_en    = 1'b1;
                adc_idx_d = '0;
                state_d   = StAccum;
            end
            StAccum: begin
                acc_we = 1'b1;
                if (adc_idx_q == IdxW'(NUM_ADC - 1)) begin
                    adc_idx_d = '0;
                    if (plane_q == PlaneW'(NUM_PLANES - 1)) begin
                        plane_d     = '0;
                        state_d     = StDrain;
                        res_valid_d = 1'b1;
                        res_idx_d   = '0;
                        // With a single ADC, entry 0 is being written this very cycle.
                        res_data_d  = (NUM_ADC == 1) ? acc_sum : acc_q[0];
                        res_last_d  = (NUM_ADC == 1);
                    end else begin
                        plane_d = plane_q + PlaneW'(1);
                        state_d = StWait;
                    end
                end else begin
                    adc_idx_d = adc_idx_q + IdxW'(1);
                end
            end
            StDrain: begin
                if (res_valid_q && res_ready) begin
                    if (res_last_q) begin
                        state_d     = StIdle;
                        res_valid_d = 1'b0;
                        res_idx_d   = '0;
                        res_data_d  = '0;
                        res_last_d  = 1'b0;
                    end else begin
                        res_idx_d  = res_idx_nxt;
                        res_data_d = acc_q[res_idx_nxt];
                        res_last_d = (res_idx_nxt == IdxW'(NUM_ADC - 1));
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge CLK or negedge RSTb) begin
        if (!RSTb) begin
            state_q     <= StIdle;
            cnt_q       <= '0;
            adc_idx_q   <= '0;
            plane_q     <= '0;
            res_valid_q <= 1'b0;
            res_data_q  <= '0;
            res_idx_q   <= '0;
            res_last_q  <= 1'b0;
            conv_err_q  <= 1'b0;
            cap_p_q     <= '0;
            cap_n_q     <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            adc_idx_q   <= adc_idx_d;
            plane_q     <= plane_d;
            res_valid_q <= res_valid_d;
            res_data_q  <= res_data_d;
            res_idx_q   <= res_idx_d;
            res_last_q  <= res_last_d;
            conv_err_q  <= conv_err_d;
            if (cap_en) begin
                cap_p_q <= outp;
                cap_n_q <= outn;
            end
        end
    end

    // Plane 0 overwrites, so the array needs no reset.
    always_ff @(posedge CLK) begin
        if (acc_we) begin
            acc_q[adc_idx_q] <= acc_sum;
        end
    end

`ifdef ADC_BUBBLE_CHECK_EN
    logic bubble_q;
    logic bubble_det;

    // A 0 below a 1 means the thermometer code is not monotonic.
    always_comb begin
        bubble_det = 1'b0;
        for (int i = 0; i < int'(NUM_ADC); i++) begin
            for (int j = 0; j < int'(THERM_WIDTH) - 1; j++) begin
                if ((!outp[i * THERM_WIDTH + j] && outp[i * THERM_WIDTH + j + 1]) ||
                    (!outn[i * THERM_WIDTH + j] && outn[i * THERM_WIDTH + j + 1])) begin
                    bubble_det = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge CLK or negedge RSTb) begin
        if (!RSTb) begin
            bubble_q <= 1'b0;
        end else if (state_q == StCapture && bubble_det) begin
            bubble_q <= 1'b1;
        end
    end

    assign bubble_err = bubble_q;
`else
    assign bubble_err = 1'b0;
`endif

    assign busy      = (state_q != StIdle);
    assign plane_idx = plane_q;
    assign res_valid = res_valid_q;
    assign res_data  = res_data_q;
    assign res_idx   = res_idx_q;
    assign res_last  = res_last_q;
    assign conv_err  = conv_err_q;

endmodule

// File: tb/tb_adc_readout_accum.sv
// Directed bench for adc_readout_accum: full frames, single-plane, random codes with stalls,
// conv_done misuse, bubble codes and reset during drain.
module tb_adc_readout_accum;

    localparam int NA = 32;
    localparam int TW = 15;
    localparam int NP = 4;
`ifdef ADC_BUBBLE_CHECK_EN
    localparam int BubbleExp = 1;
`else
    localparam int BubbleExp = 0;
`endif

    logic           CLK = 1'b0;
    logic           RSTb;
    logic           conv_done;
    logic [TW*NA-1:0] outp, outn;
    logic           busy;
    logic [1:0]     plane_idx;
    logic           res_valid;
    logic           res_ready;
    logic [8:0]     res_data;
    logic [4:0]     res_idx;
    logic           res_last;
    logic           conv_err;
    logic           bubble_err;

    adc_readout_accum dut (
        .CLK        (CLK),
        .RSTb       (RSTb),
        .conv_done  (conv_done),
        .outp       (outp),
        .outn       (outn),
        .busy       (busy),
        .plane_idx  (plane_idx),
        .res_valid  (res_valid),
        .res_ready  (res_ready),
        .res_data   (res_data),
        .res_idx    (res_idx),
        .res_last   (res_last),
        .conv_err   (conv_err),
        .bubble_err (bubble_err)
    );

    always #5 CLK = ~CLK;

    int checks   = 0;
    int failures = 0;
    logic [TW-1:0] pc [NP][NA];
    logic [TW-1:0] nc [NP][NA];
    int exp_res [NA];
    int drain_cyc;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0d, expected %0d", tag, $signed(got), $signed(exp));
        end
    endtask

    function automatic logic [TW-1:0] therm(input int n);
        return TW'((32'd1 << n) - 32'd1);
    endfunction

    task automatic clear_codes();
        for (int p = 0; p < NP; p++) begin
            for (int i = 0; i < NA; i++) begin
                pc[p][i] = '0;
                nc[p][i] = '0;
            end
        end
    endtask

    task automatic compute_model();
        for (int i = 0; i < NA; i++) begin
            exp_res[i] = 0;
            for (int p = 0; p < NP; p++) begin
                exp_res[i] += ($countones(pc[p][i]) - $countones(nc[p][i])) * (1 << p);
            end
        end
    endtask

    task automatic check_reset_vals();
        check_eq("rst_busy", 32'(busy), 0);
        check_eq("rst_plane_idx", 32'(plane_idx), 0);
        check_eq("rst_res_valid", 32'(res_valid), 0);
        check_eq("rst_res_data", 32'(res_data), 0);
        check_eq("rst_res_idx", 32'(res_idx), 0);
        check_eq("rst_res_last", 32'(res_last), 0);
        check_eq("rst_conv_err", 32'(conv_err), 0);
        check_eq("rst_bubble_err", 32'(bubble_err), 0);
    endtask

    task automatic do_reset();
        RSTb      = 1'b0;
        conv_done = 1'b0;
        res_ready = 1'b0;
        outp      = '0;
        outn      = '0;
        repeat (2) @(negedge CLK);
        RSTb = 1'b1;
        @(negedge CLK);
    endtask

    task automatic pulse_conv();
        @(negedge CLK);
        conv_done = 1'b1;
        @(negedge CLK);
        conv_done = 1'b0;
    endtask

    task automatic run_frame(input bit glitch);
        for (int p = 0; p < NP; p++) begin
            for (int i = 0; i < NA; i++) begin
                outp[i*TW +: TW] = pc[p][i];
                outn[i*TW +: TW] = nc[p][i];
            end
            pulse_conv();
            // Second pulse lands in SETTLE and must be ignored.
            if (glitch && p == 1) pulse_conv();
            repeat (40) @(negedge CLK);
            if (p == 0) begin
                check_eq("wait_plane_idx", 32'(plane_idx), 1);
                check_eq("wait_busy", 32'(busy), 1);
            end
        end
    endtask

    task automatic drain(input bit rand_ready, input int stop_at);
        int  hs = 0;
        int  cyc = 0;
        bit  stalled = 0;
        bit  aborted = 0;
        logic [8:0] pd = '0;
        logic [4:0] pi = '0;
        while (hs < NA && cyc < 2000) begin
            @(negedge CLK);
            cyc++;
            if (res_valid) begin
                if (stalled) begin
                    check_eq("stall_data", 32'(res_data), 32'(pd));
                    check_eq("stall_idx", 32'(res_idx), 32'(pi));
                end
                check_eq("res_idx", 32'(res_idx), hs);
                check_eq("res_data", 32'($signed(res_data)), exp_res[hs]);
                check_eq("res_last", 32'(res_last), 32'(hs == NA - 1));
                if (stop_at == hs) begin
                    RSTb      = 1'b0;
                    res_ready = 1'b0;
                    #1;
                    check_reset_vals();
                    @(negedge CLK);
                    RSTb    = 1'b1;
                    aborted = 1;
                    break;
                end
                res_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
                if (res_ready) begin
                    hs++;
                    stalled = 0;
                end else begin
                    stalled = 1;
                    pd = res_data;
                    pi = res_idx;
                end
            end else begin
                res_ready = 1'b0;
            end
        end
        drain_cyc = cyc;
        if (!aborted) begin
            check_eq("handshakes", hs, NA);
            @(negedge CLK);
            res_ready = 1'b0;
            check_eq("post_valid", 32'(res_valid), 0);
            check_eq("post_busy", 32'(busy), 0);
        end
    endtask

    initial begin
        do_reset();
        check_reset_vals();

        // Full-scale positive on every ADC and plane.
        clear_codes();
        for (int p = 0; p < NP; p++)
            for (int i = 0; i < NA; i++) pc[p][i] = therm(15);
        compute_model();
        run_frame(0);
        drain(0, -1);
        check_eq("drain_cycles", drain_cyc, NA);
        check_eq("allpos_conv_err", 32'(conv_err), 0);
        check_eq("allpos_bubble_err", 32'(bubble_err), 0);

        // Plane 2 only, ADC 5: 3 - 10 = -7, times 4.
        clear_codes();
        pc[2][5] = therm(3);
        nc[2][5] = therm(10);
        compute_model();
        run_frame(0);
        drain(1, -1);

        // Random monotonic codes with a stalling consumer.
        for (int p = 0; p < NP; p++)
            for (int i = 0; i < NA; i++) begin
                pc[p][i] = therm(int'($urandom_range(0, 15)));
                nc[p][i] = therm(int'($urandom_range(0, 15)));
            end
        compute_model();
        run_frame(0);
        drain(1, -1);

        // conv_done during SETTLE of plane 1.
        do_reset();
        run_frame(1);
        check_eq("glitch_conv_err", 32'(conv_err), 1);
        drain(0, -1);

        // Non-monotonic code on ADC 2 still decodes by popcount.
        do_reset();
        clear_codes();
        pc[0][2] = 15'b000000000000101;
        compute_model();
        run_frame(0);
        check_eq("bubble_err", 32'(bubble_err), BubbleExp);
        drain(0, -1);

        // Reset in the middle of DRAIN, then a clean frame.
        do_reset();
        clear_codes();
        for (int p = 0; p < NP; p++)
            for (int i = 0; i < NA; i++) begin
                pc[p][i] = therm(i % 16);
                nc[p][i] = therm(p + 2);
            end
        compute_model();
        run_frame(0);
        drain(0, 10);
        @(negedge CLK);
        run_frame(0);
        drain(0, -1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/adc_readout_accum.md
# adc_readout_accum

- Downstream consumer of the RRAM crossbar macro's ADC outputs.
- Per conversion, captures the thermometer-coded `outp`/`outn` buses and decodes each ADC pair to a signed difference.
- Shift-accumulates that difference across `NUM_PLANES` bit-serial input planes.
- After the last plane, streams one signed result per ADC over a valid/ready interface to the compute/readback logic.

## Interface
- `NUM_ADC`, 32, number of ADC columns.
- `ADC_WIDTH`, 4, ADC resolution in bits.
- `THERM_WIDTH`, 15, thermometer bits per ADC; must equal 2^`ADC_WIDTH`-1.
- `NUM_PLANES`, 4, input bit-planes per frame.
- `SETTLE_CYC`, 4, wait cycles between `conv_done` and capture; must be ≥1.
- `ACC_WIDTH`, 9, result width; must equal `ADC_WIDTH`+`NUM_PLANES`+1.
- `CLK` input 1, sole clock.
- `RSTb` input 1, asynchronous active-low reset.
- `conv_done` input 1, one-cycle pulse: ADC conversion for the current plane is complete.
- `outp` input `THERM_WIDTH*NUM_ADC`, positive thermometer codes from the macro.
- `outn` input `THERM_WIDTH*NUM_ADC`, negative thermometer codes from the macro.
- `busy` output 1, high in any state except IDLE.
- `plane_idx` output $clog2(`NUM_PLANES`), index of the plane expected next.
- `res_valid` output 1, result available.
- `res_ready` input 1, consumer accepts the result.
- `res_data` output `ACC_WIDTH`, signed two's-complement result.
- `res_idx` output $clog2(`NUM_ADC`), ADC index of `res_data`.
- `res_last` output 1, high with `res_idx`=`NUM_ADC`-1.
- `conv_err` output 1, sticky: `conv_done` arrived while not accepting.
- `bubble_err` output 1, sticky: non-monotonic thermometer code seen.

## Operation
- ADC i uses bits [`THERM_WIDTH`*i +: `THERM_WIDTH`]. Its value is the popcount of those bits (0..15; bubble-tolerant).
- Per ADC: d = pop(p) − pop(n), range −15..+15. Contribution to the accumulator is d << plane_idx (plane 0 is the LSB).
- States:
  - IDLE: `conv_done` → SETTLE, counter loaded with `SETTLE_CYC`-1.
  - SETTLE: counts down; at 0 → CAPTURE.
  - CAPTURE: `outp`/`outn` registered into capture flops (one cycle) → ACCUM.
  - ACCUM: one ADC per cycle, index 0..`NUM_ADC`-1. Plane 0 overwrites acc[i]; planes >0 add. After ADC `NUM_ADC`-1: if plane_idx=`NUM_PLANES`-1 → DRAIN with plane_idx cleared to 0; else plane_idx+1 → WAIT.
  - WAIT: `conv_done` → SETTLE.
  - DRAIN: presents acc[`res_idx`]. On `res_valid`&&`res_ready`, `res_idx` increments. The handshake with `res_last` → IDLE with `res_idx`=0.
- `conv_done` is accepted only in IDLE and WAIT. Anywhere else it is ignored and sets `conv_err`.
- Accumulator cannot overflow at `ACC_WIDTH`: range is ±15·(2^`NUM_PLANES`-1) = ±225.
- Accumulator storage is `NUM_ADC`×`ACC_WIDTH` flops. It is not cleared in reset beyond the overwrite-on-plane-0 rule.

## Timing
- Reset values: `busy`=0, `plane_idx`=0, `res_valid`=0, `res_data`=0, `res_idx`=0, `res_last`=0, `conv_err`=0, `bubble_err`=0. State=IDLE; capture flops=0.
- `RSTb` assertion mid-operation aborts immediately (asynchronous). The next frame starts at plane 0.
- `conv_done` at cycle t → capture at cycle t+`SETTLE_CYC`+1 → ACCUM cycles t+`SETTLE_CYC`+2 .. t+`SETTLE_CYC`+`NUM_ADC`+1.
- After the last plane's ACCUM, `res_valid` rises on the next cycle.
- `res_valid`, `res_data`, `res_idx` and `res_last` are registered. They hold stable while `res_valid`&&!`res_ready`.
- With `res_ready` held high, DRAIN takes exactly `NUM_ADC` cycles. `busy` falls the cycle after the last handshake.
- `conv_done` in the same cycle as the final handshake is ignored and sets `conv_err`. The state that cycle is DRAIN.

## Configuration
- `ADC_BUBBLE_CHECK_EN` defined:
  - in CAPTURE, any ADC code with bit j=0 and bit j+1=1 (p or n) sets `bubble_err` one cycle later;
  - decoding still uses popcount.
- `ADC_BUBBLE_CHECK_EN` undefined: `bubble_err` is tied 0 and no check logic is synthesized.

## Test plan
- All planes, every ADC p=15 ones, n=0; `res_ready`=1 → 32 results of +225, `res_last` on idx 31, `busy` low afterwards.
- Plane k only: ADC 5 p=3 ones, n=10 ones (other planes and ADCs zero) → ADC 5 result = −7·2^k; others 0.
- Random codes; `res_ready` toggling 50% → each result matches the model. `res_data` is stable during stalls; exactly 32 handshakes.
- `conv_done` during SETTLE of plane 1 → `conv_err`=1; frame still completes with correct data after further plane pulses.
- With `ADC_BUBBLE_CHECK_EN`: ADC 2 p code 0b000000000000101 → `bubble_err`=1 and the decoded value counts 2 ones. Without the macro, `bubble_err`=0.
- `RSTb` low for 1 cycle in the middle of DRAIN (idx 10) → all outputs at reset values. A following full frame produces correct results from idx 0.
